// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: register file geometry,
// the hard-wired zero register and the drain handshake states.
package vi_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;

    // x0 reads as zero and is never the target of a tracked write.
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    // RUN issues normally, DRAIN waits for the pipeline to empty,
    // DONE reports completion for exactly one cycle.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/issue_scoreboard_hazard.sv
// Combinational RAW/WAW hazard detection against the pending-write map.
// The writeback mask removes registers that are being written back this
// cycle (all zero unless writeback-to-decode forwarding is enabled).
module sb_hazard_check #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [NREGS-1:0]  pending_i,
    input  logic [NREGS-1:0]  wb_mask_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    input  logic [ADDR_W-1:0] rs3_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              use_a_i,
    input  logic              use_b_i,
    input  logic              use_rs3_i,
    input  logic              write_en_i,
    output logic              hazard_o
);

    import vi_pkg::*;

    logic [NREGS-1:0] effPending;

    // A source or destination conflicts when its register still has an
    // outstanding write; x0 can never conflict.
    always_comb begin
        effPending     = pending_i & ~wb_mask_i;
        effPending[X0] = 1'b0;
        hazard_o = (use_a_i    & effPending[rs1_i]) |
                   (use_b_i    & effPending[rs2_i]) |
                   (use_rs3_i  & effPending[rs3_i]) |
                   (write_en_i & effPending[rd_i]);
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks outstanding register writes, holds back decoded
// instructions with RAW/WAW hazards, sequences a drain handshake and counts
// stalled decode cycles.
// Optional feature: define SCOREBOARD_BYPASS_EN to let a writeback in the
// current cycle satisfy a dependent instruction in that same cycle.
module issue_scoreboard #(
    parameter int NREGS  = vi_pkg::NREGS,
    parameter int ADDR_W = vi_pkg::REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [ADDR_W-1:0] read_addr_a_i,
    input  logic [ADDR_W-1:0] read_addr_b_i,
    input  logic [ADDR_W-1:0] rs3_i,
    input  logic              use_a_i,
    input  logic              use_b_i,
    input  logic              use_rs3_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic              int_write_enable_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic              flush_i,
    input  logic              drain_i,
    output logic              drain_done_o,
    output logic [NREGS-1:0]  pending_o,
    output logic [ADDR_W:0]   inflight_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              wb_err_o
);

    import vi_pkg::*;

    localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

    sb_state_t         state_q, state_d;
    logic [NREGS-1:0]  pending_q, pending_d;
    logic [ADDR_W:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              wb_err_q, wb_err_d;

    logic              hazard;
    logic              issue;
    logic              setEn;
    logic              wbLegal;
    logic [NREGS-1:0]  setVec;
    logic [NREGS-1:0]  clrVec;
    logic [NREGS-1:0]  bypassMask;

    assign wbLegal = wb_valid_i & (wb_addr_i != X0) & pending_q[wb_addr_i];
    assign clrVec  = wbLegal ? (ONE_HOT0 << wb_addr_i) : '0;

`ifdef SCOREBOARD_BYPASS_EN
    assign bypassMask = clrVec;
`else
    assign bypassMask = '0;
`endif

    sb_hazard_check #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_hazard (
        .pending_i  (pending_q),
        .wb_mask_i  (bypassMask),
        .rs1_i      (read_addr_a_i),
        .rs2_i      (read_addr_b_i),
        .rs3_i      (rs3_i),
        .rd_i       (write_addr_i),
        .use_a_i    (use_a_i),
        .use_b_i    (use_b_i),
        .use_rs3_i  (use_rs3_i),
        .write_en_i (int_write_enable_i),
        .hazard_o   (hazard)
    );

    assign dec_ready_o  = (state_q == RUN) & ~hazard & ~flush_i;
    assign drain_done_o = (state_q == DONE);
    assign issue        = dec_valid_i & dec_ready_o;
    assign setEn        = issue & int_write_enable_i & (write_addr_i != X0);
    assign setVec       = setEn ? (ONE_HOT0 << write_addr_i) : '0;

    // Pending map, in-flight count and sticky writeback error; a set and a
    // clear of the same register leave it set with the count unchanged.
    always_comb begin
        pending_d  = pending_q;
        inflight_d = inflight_q;
        wb_err_d   = wb_err_q;
        if (flush_i) begin
            pending_d  = '0;
            inflight_d = '0;
        end else begin
            pending_d  = (pending_q & ~clrVec) | setVec;
            inflight_d = inflight_q + {{ADDR_W{1'b0}}, setEn}
                                    - {{ADDR_W{1'b0}}, wbLegal};
            if (wb_valid_i && !wbLegal) begin
                wb_err_d = 1'b1;
            end
        end
        pending_d[X0] = 1'b0;
    end

    // Count cycles where the decoder is held off, stopping at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (dec_valid_i && !dec_ready_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Drain handshake: wait for an empty pipeline with no writeback still
    // landing, then pulse completion once and resume issuing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && !wb_valid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers; reset may arrive at any time, including mid-drain.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q     <= RUN;
            pending_q   <= '0;
            inflight_q  <= '0;
            stall_cnt_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            inflight_q  <= inflight_d;
            stall_cnt_q <= stall_cnt_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign pending_o   = pending_q;
    assign inflight_o  = inflight_q;
    assign stall_cnt_o = stall_cnt_q;
    assign wb_err_o    = wb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard (stall counter built 4 bits wide so
// saturation is reachable). The driver advances a register-level reference
// model and queues the expected outputs; a monitor compares them.
// Honours SCOREBOARD_BYPASS_EN in the reference model.
module tb_issue_scoreboard;

    localparam int STALL_MAX = 15;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rsn = 1'b0;
    logic        decValid, decReady;
    logic [4:0]  rs1, rs2, rs3;
    logic        useA, useB, use3;
    logic [4:0]  rd;
    logic        we, wbValid, flush, drain;
    logic [4:0]  wbAddr;
    logic        drainDone, wbErr;
    logic [31:0] pending;
    logic [5:0]  inflight;
    logic [3:0]  stallCnt;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1, rs2, rs3;
        logic       ua, ub, u3;
        logic [4:0] rd;
        logic       we;
        logic       wbv;
        logic [4:0] wba;
        logic       flush;
        logic       drain;
    } stim_t;

    typedef struct packed {
        logic        ready;
        logic        done;
        logic [31:0] pend;
        logic [5:0]  infl;
        logic [3:0]  stall;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: a set of registers awaiting writeback plus the
    // drain progress flags.
    bit pendM[32];
    int stallM;
    bit errM, inDrain, donePulse;

    issue_scoreboard #(.NREGS(32), .ADDR_W(5), .CNT_W(4)) dut (
        .clk_i              (clk),
        .rsn_i              (rsn),
        .dec_valid_i        (decValid),
        .dec_ready_o        (decReady),
        .read_addr_a_i      (rs1),
        .read_addr_b_i      (rs2),
        .rs3_i              (rs3),
        .use_a_i            (useA),
        .use_b_i            (useB),
        .use_rs3_i          (use3),
        .write_addr_i       (rd),
        .int_write_enable_i (we),
        .wb_valid_i         (wbValid),
        .wb_addr_i          (wbAddr),
        .flush_i            (flush),
        .drain_i            (drain),
        .drain_done_o       (drainDone),
        .pending_o          (pending),
        .inflight_o         (inflight),
        .stall_cnt_o        (stallCnt),
        .wb_err_o           (wbErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < 32; i++) if (pendM[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] modelVec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = pendM[i];
        return v;
    endfunction

    // A register blocks decode if it awaits a write, unless forwarding is
    // enabled and its legitimate writeback happens this very cycle.
    function automatic bit blocks(input stim_t s, input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (BYPASS && s.wbv && s.wba == r && pendM[r]) return 1'b0;
        return pendM[r];
    endfunction

    function automatic stim_t idleStim();
        stim_t s = '0;
        return s;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 32; i++) pendM[i] = 1'b0;
        stallM    = 0;
        errM      = 1'b0;
        inDrain   = 1'b0;
        donePulse = 1'b0;
    endtask

    task automatic driveIdle();
        decValid = 0; rs1 = 0; rs2 = 0; rs3 = 0; useA = 0; useB = 0; use3 = 0;
        rd = 0; we = 0; wbValid = 0; wbAddr = 0; flush = 0; drain = 0;
    endtask

    // Drive one cycle, queue what the outputs must show during it, then
    // advance the model across the coming clock edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   hz, rdy, wbOk;
        int   cnt;
        @(negedge clk);
        decValid = s.valid; rs1 = s.rs1; rs2 = s.rs2; rs3 = s.rs3;
        useA = s.ua; useB = s.ub; use3 = s.u3; rd = s.rd; we = s.we;
        wbValid = s.wbv; wbAddr = s.wba; flush = s.flush; drain = s.drain;
        hz  = (s.ua && blocks(s, s.rs1)) || (s.ub && blocks(s, s.rs2)) ||
              (s.u3 && blocks(s, s.rs3)) || (s.we && blocks(s, s.rd));
        rdy = !inDrain && !donePulse && !hz && !s.flush;
        cnt = modelCount();
        e.ready = rdy;
        e.done  = donePulse;
        e.pend  = modelVec();
        e.infl  = 6'(cnt);
        e.stall = 4'(stallM);
        e.err   = errM;
        expQ.push_back(e);
        if (s.valid && !rdy && stallM < STALL_MAX) stallM++;
        if (donePulse) donePulse = 1'b0;
        else if (inDrain) begin
            if (cnt == 0 && !s.wbv) begin
                inDrain   = 1'b0;
                donePulse = 1'b1;
            end
        end else if (s.drain) inDrain = 1'b1;
        if (s.flush) begin
            for (int i = 0; i < 32; i++) pendM[i] = 1'b0;
        end else begin
            wbOk = s.wbv && s.wba != 5'd0 && pendM[s.wba];
            if (s.wbv && !wbOk) errM = 1'b1;
            if (wbOk) pendM[s.wba] = 1'b0;
            if (s.valid && rdy && s.we && s.rd != 5'd0) pendM[s.rd] = 1'b1;
        end
    endtask

    // Monitor: compare each queued expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cyc_ready",    64'(decReady),  64'(e.ready));
                checkOutput("cyc_done",     64'(drainDone), 64'(e.done));
                checkOutput("cyc_pending",  64'(pending),   64'(e.pend));
                checkOutput("cyc_inflight", 64'(inflight),  64'(e.infl));
                checkOutput("cyc_stall",    64'(stallCnt),  64'(e.stall));
                checkOutput("cyc_wberr",    64'(wbErr),     64'(e.err));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        int    r;
        driveIdle();
        resetModel();
        #1 rsn = 1'b1;
        #2;
        checkOutput("reset_pending",  64'(pending),   64'd0);
        checkOutput("reset_inflight", 64'(inflight),  64'd0);
        checkOutput("reset_stall",    64'(stallCnt),  64'd0);
        checkOutput("reset_wberr",    64'(wbErr),     64'd0);
        checkOutput("reset_done",     64'(drainDone), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rsn = 1'b0;
        #2 checkOutput("ready_after_reset", 64'(decReady), 64'd1);

        // Single producer/consumer on x5.
        s = idleStim(); s.valid = 1; s.we = 1; s.rd = 5; applyStimulus(s);
        s = idleStim(); applyStimulus(s);
        #2 checkOutput("x5_pending", 64'(pending), 64'h20);
        checkOutput("x5_inflight", 64'(inflight), 64'd1);
        s = idleStim(); s.valid = 1; s.ua = 1; s.rs1 = 5; applyStimulus(s);
        #2 checkOutput("x5_raw_block", 64'(decReady), 64'd0);
        s.wbv = 1; s.wba = 5; applyStimulus(s);
        #2 checkOutput("x5_wb_cycle_ready", 64'(decReady), 64'(BYPASS));
        s = idleStim(); s.valid = 1; s.ua = 1; s.rs1 = 5; applyStimulus(s);
        #2 checkOutput("x5_after_wb_ready", 64'(decReady), 64'd1);

        // x0 is never tracked; writeback to it is an error.
        s = idleStim(); s.valid = 1; s.we = 1; s.rd = 0; applyStimulus(s);
        s = idleStim(); s.valid = 1; s.ua = 1; s.rs1 = 0; applyStimulus(s);
        #2 checkOutput("x0_dep_ready", 64'(decReady), 64'd1);
        checkOutput("x0_pending", 64'(pending), 64'd0);
        s = idleStim(); s.wbv = 1; s.wba = 0; applyStimulus(s);
        s = idleStim(); applyStimulus(s);
        #2 checkOutput("x0_wb_err", 64'(wbErr), 64'd1);

        // Fill every register, then flush with a competing issue.
        for (int i = 1; i < 32; i++) begin
            s = idleStim(); s.valid = 1; s.we = 1; s.rd = 5'(i); applyStimulus(s);
        end
        s = idleStim(); applyStimulus(s);
        #2 checkOutput("fill_inflight", 64'(inflight), 64'd31);
        checkOutput("fill_pending", 64'(pending), 64'hFFFF_FFFE);
        s = idleStim(); s.flush = 1; s.valid = 1; s.we = 1; s.rd = 7; applyStimulus(s);
        s = idleStim(); applyStimulus(s);
        #2 checkOutput("flush_pending", 64'(pending), 64'd0);
        checkOutput("flush_inflight", 64'(inflight), 64'd0);

        // Drain with x3 and x4 outstanding.
        s = idleStim(); s.valid = 1; s.we = 1; s.rd = 3; applyStimulus(s);
        s.rd = 4; applyStimulus(s);
        s = idleStim(); s.drain = 1; applyStimulus(s);
        s = idleStim(); s.valid = 1; s.ua = 1; s.rs1 = 9; applyStimulus(s);
        #2 checkOutput("drain_blocks", 64'(decReady), 64'd0);
        s = idleStim(); s.wbv = 1; s.wba = 3; applyStimulus(s);
        s.wba = 4; applyStimulus(s);
        s = idleStim(); applyStimulus(s);
        applyStimulus(s);
        #2 checkOutput("drain_done_pulse", 64'(drainDone), 64'd1);
        applyStimulus(s);
        #2 checkOutput("drain_done_single", 64'(drainDone), 64'd0);
        checkOutput("drain_ready_again", 64'(decReady), 64'd1);

        // Stall counting and saturation.
        @(negedge clk); #3 rsn = 1'b1; driveIdle(); resetModel();
        @(negedge clk); rsn = 1'b0;
        s = idleStim(); s.valid = 1; s.we = 1; s.rd = 9; applyStimulus(s);
        s = idleStim(); s.valid = 1; s.ua = 1; s.rs1 = 9;
        for (int i = 0; i < 10; i++) applyStimulus(s);
        s = idleStim(); applyStimulus(s);
        #2 checkOutput("stall_10", 64'(stallCnt), 64'd10);
        s = idleStim(); s.valid = 1; s.ub = 1; s.rs2 = 9;
        for (int i = 0; i < 10; i++) applyStimulus(s);
        s = idleStim(); applyStimulus(s);
        #2 checkOutput("stall_saturate", 64'(stallCnt), 64'd15);
        s = idleStim(); s.wbv = 1; s.wba = 9; applyStimulus(s);

        // Asynchronous reset in the middle of a drain.
        s = idleStim(); s.valid = 1; s.we = 1; s.rd = 3; applyStimulus(s);
        s.rd = 4; applyStimulus(s);
        s = idleStim(); s.drain = 1; applyStimulus(s);
        s = idleStim(); applyStimulus(s);
        #3 rsn = 1'b1; driveIdle();
        #1 checkOutput("async_pending", 64'(pending), 64'd0);
        checkOutput("async_inflight", 64'(inflight), 64'd0);
        checkOutput("async_stall", 64'(stallCnt), 64'd0);
        checkOutput("async_done", 64'(drainDone), 64'd0);
        resetModel();
        @(negedge clk); rsn = 1'b0;
        #2 checkOutput("async_ready_release", 64'(decReady), 64'd1);
        s = idleStim();
        for (int i = 0; i < 3; i++) applyStimulus(s);

        // Randomised traffic over a small register window to force hazards.
        for (int c = 0; c < 1500; c++) begin
            s = idleStim();
            s.valid = ($urandom_range(0, 3) != 0);
            s.rs1 = 5'($urandom_range(0, 7));
            s.rs2 = 5'($urandom_range(0, 7));
            s.rs3 = 5'($urandom_range(0, 7));
            s.ua  = 1'($urandom_range(0, 1));
            s.ub  = 1'($urandom_range(0, 1));
            s.u3  = 1'($urandom_range(0, 1));
            s.we  = 1'($urandom_range(0, 1));
            s.rd  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                s.wbv = 1;
                r = $urandom_range(0, 31);
                if (modelCount() > 0 && $urandom_range(0, 7) != 0) begin
                    while (!pendM[r]) r = (r + 1) % 32;
                end else begin
                    r = $urandom_range(0, 7);
                end
                s.wba = 5'(r);
            end
            s.drain = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) begin
                s.flush = 1;
                s.wbv   = 0;
                s.wba   = 0;
            end
            applyStimulus(s);
        end

        #3;
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
